// File: rtl/axis_uart_rx_fifo.sv
// rtl/axis_uart_rx_fifo.sv - oversampling UART receiver with parity/framing flags feeding an AXI-Stream FIFO
// Received words are held in a first-word-fallthrough FIFO; {frame_err, parity_err} ride in m_axis_user.
module axis_uart_rx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          m_axis_data,
  output logic [1:0]                    m_axis_user,
  output logic                          m_axis_valid,
  input  logic                          m_axis_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          rx_busy
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int WW  = DATA_BITS + 2;

  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SCW-1:0] SC_HALF   = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_FULL   = SCW'(OVERSAMPLE - 1);
  localparam logic [3:0]     BC_DATA   = 4'(DATA_BITS - 1);
  localparam logic [3:0]     BC_STOP   = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0]  CNT_FULL  = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_PUSH  = 3'd5;
  localparam logic [2:0] S_BREAK = 3'd6;

  logic                 sync1_q, sync1_d, rx_s_q, rx_s_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [2:0]           state_q, state_d;
  logic [SCW-1:0]       sc_q, sc_d;
  logic [3:0]           bc_q, bc_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 tick, clr_tick, push;

  logic [WW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic                 pop, push_ok;

  assign sync1_d = rx;
  assign rx_s_d  = sync1_q;
  assign tick    = (tcnt_q == TICK_LAST);

  always_comb begin
    tcnt_d = tick ? '0 : tcnt_q + 1'b1;
    if (clr_tick) tcnt_d = '0;
  end

  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    bc_d     = bc_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    push     = 1'b0;
    clr_tick = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d  = S_START;
          sc_d     = '0;
          clr_tick = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          if (sc_q == SC_HALF) begin
            sc_d    = '0;
            bc_d    = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (sc_q == SC_FULL) begin
            sc_d    = '0;
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bc_q == BC_DATA) begin
              bc_d    = '0;
              state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bc_d = bc_q + 1'b1;
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (tick) begin
          if (sc_q == SC_FULL) begin
            sc_d    = '0;
            perr_d  = (PARITY == 1) ? (^shift_q ^ rx_s_q) : ~(^shift_q ^ rx_s_q);
            state_d = S_STOP;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (sc_q == SC_FULL) begin
            sc_d = '0;
            if (!rx_s_q) ferr_d = 1'b1;
            // Leave at the mid-stop sample so a back-to-back start edge is not missed
            if (bc_q == BC_STOP) state_d = S_PUSH;
            else bc_d = bc_q + 1'b1;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      S_PUSH: begin
        push    = 1'b1;
        state_d = ferr_q ? S_BREAK : S_IDLE;
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign m_axis_valid = (count_q != '0);
  assign pop          = m_axis_valid & m_axis_ready;
  assign push_ok      = push & ((count_q != CNT_FULL) | pop);

  always_comb begin
    wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overrun_d = push & ~push_ok;
    count_d   = count_q;
    if (push_ok && !pop) count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      tcnt_q    <= '0;
      state_q   <= S_IDLE;
      sc_q      <= '0;
      bc_q      <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      rx_s_q    <= rx_s_d;
      tcnt_q    <= tcnt_d;
      state_q   <= state_d;
      sc_q      <= sc_d;
      bc_q      <= bc_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {ferr_q, perr_q, shift_q};
  end

  // Storage is not reset, so gate the read port to keep outputs at 0 while empty
  assign m_axis_data = m_axis_valid ? mem_q[rd_ptr_q][DATA_BITS-1:0] : '0;
  assign m_axis_user = m_axis_valid ? mem_q[rd_ptr_q][WW-1:DATA_BITS] : 2'b00;
  assign fifo_count  = count_q;
  assign overrun     = overrun_q;
  assign rx_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_axis_uart_rx_fifo.sv
// tb/tb_axis_uart_rx_fifo.sv - directed bench for axis_uart_rx_fifo (8E1 and 7N2 instances)
module tb_axis_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1, rx2 = 1'b1;
  logic       ready = 1'b0, ready2 = 1'b1;
  logic [7:0] data;
  logic [6:0] data2;
  logic [1:0] user, user2;
  logic       valid, valid2, ovr, ovr2, busy, busy2;
  logic [4:0] count, count2;

  int n_vec = 0;
  int n_err = 0;
  int ov_cnt = 0;
  logic [9:0] q1[$];
  logic [8:0] q2[$];

  always #5 clk = ~clk;

  axis_uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
                      .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .m_axis_data(data), .m_axis_user(user),
    .m_axis_valid(valid), .m_axis_ready(ready), .fifo_count(count),
    .overrun(ovr), .rx_busy(busy));

  axis_uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(7),
                      .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) dut2 (
    .clk(clk), .rst(rst), .rx(rx2), .m_axis_data(data2), .m_axis_user(user2),
    .m_axis_valid(valid2), .m_axis_ready(ready2), .fifo_count(count2),
    .overrun(ovr2), .rx_busy(busy2));

  always @(negedge clk) begin
    if (!rst && valid && ready) q1.push_back({user, data});
    if (!rst && valid2 && ready2) q2.push_back({user2, data2});
    if (ovr) ov_cnt++;
  end

  function automatic logic [15:0] f8(input logic [7:0] d, input logic bad_par, input logic stop);
    f8 = {5'b11111, stop, (^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic send_raw(input logic sel, input logic [15:0] bits, input int n);
    for (int b = 0; b < n; b++) begin
      if (sel) rx2 = bits[b]; else rx = bits[b];
      repeat (16) @(posedge clk);
      #1;
    end
    if (sel) rx2 = 1'b1; else rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if ({ovr, busy, user, data} !== 12'h000) begin n_err++; $display("FAIL reset_outs: got %h want 000", {ovr, busy, user, data}); end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_basic;
    q1.delete();
    ready = 1'b1;
    fork
      send_raw(1'b0, f8(8'hA5, 1'b0, 1'b1), 11);
      begin
        repeat (171) @(posedge clk);
        #1;
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL lat_pre: got %b want 0", valid); end
        @(posedge clk); #1;
        n_vec++; if ({valid, user, data} !== {1'b1, 2'b00, 8'hA5}) begin n_err++; $display("FAIL lat_beat: got %h want %h", {valid, user, data}, {1'b1, 2'b00, 8'hA5}); end
        @(posedge clk); #1;
        n_vec++; if ({valid, count} !== 6'd0) begin n_err++; $display("FAIL lat_drain: got %h want 0", {valid, count}); end
      end
    join
    idle(10);
    n_vec++; if (q1.size() !== 1) begin n_err++; $display("FAIL basic_beats: got %0d want 1", q1.size()); end
  endtask

  task automatic test_errors;
    q1.delete();
    send_raw(1'b0, f8(8'h3C, 1'b1, 1'b1), 11);
    send_raw(1'b0, f8(8'h3C, 1'b0, 1'b0), 11);
    idle(20);
    n_vec++; if (q1.size() !== 2) begin n_err++; $display("FAIL err_beats: got %0d want 2", q1.size()); end
    else begin
      n_vec++; if (q1[0] !== {2'b01, 8'h3C}) begin n_err++; $display("FAIL parity_err: got %h want %h", q1[0], {2'b01, 8'h3C}); end
      n_vec++; if (q1[1] !== {2'b10, 8'h3C}) begin n_err++; $display("FAIL frame_err: got %h want %h", q1[1], {2'b10, 8'h3C}); end
    end
  endtask

  task automatic test_glitch_break;
    q1.delete();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(1);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy: got %b want 1", busy); end
    idle(7);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_idle: got %b want 0", busy); end
    idle(20);
    n_vec++; if (q1.size() !== 0) begin n_err++; $display("FAIL glitch_push: got %0d want 0", q1.size()); end
    rx = 1'b0;
    idle(3 * 176);
    rx = 1'b1;
    idle(20);
    send_raw(1'b0, f8(8'h81, 1'b0, 1'b1), 11);
    idle(20);
    n_vec++; if (q1.size() !== 2) begin n_err++; $display("FAIL break_beats: got %0d want 2", q1.size()); end
    else begin
      n_vec++; if (q1[0] !== {2'b10, 8'h00}) begin n_err++; $display("FAIL break_word: got %h want %h", q1[0], {2'b10, 8'h00}); end
      n_vec++; if (q1[1] !== {2'b00, 8'h81}) begin n_err++; $display("FAIL after_break: got %h want %h", q1[1], {2'b00, 8'h81}); end
    end
  endtask

  task automatic test_overrun;
    q1.delete();
    ready = 1'b0;
    ov_cnt = 0;
    for (int i = 0; i < 16; i++) send_raw(1'b0, f8(8'(i), 1'b0, 1'b1), 11);
    idle(4);
    n_vec++; if (ov_cnt !== 0) begin n_err++; $display("FAIL ov_early: got %0d want 0", ov_cnt); end
    send_raw(1'b0, f8(8'h10, 1'b0, 1'b1), 11);
    idle(4);
    n_vec++; if (ov_cnt !== 1) begin n_err++; $display("FAIL ov_pulse: got %0d want 1", ov_cnt); end
    n_vec++; if (count !== 5'd16) begin n_err++; $display("FAIL ov_count: got %0d want 16", count); end
    n_vec++; if ({valid, user, data} !== {1'b1, 2'b00, 8'h00}) begin n_err++; $display("FAIL ov_hold: got %h want %h", {valid, user, data}, {1'b1, 2'b00, 8'h00}); end
    ready = 1'b1;
    idle(20);
    n_vec++; if (q1.size() !== 16) begin n_err++; $display("FAIL drain_n: got %0d want 16", q1.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        n_vec++; if (q1[i] !== {2'b00, 8'(i)}) begin n_err++; $display("FAIL drain_%0d: got %h want %h", i, q1[i], {2'b00, 8'(i)}); end
      end
    end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b want 0", valid); end
  endtask

  task automatic test_full_pushpop;
    q1.delete();
    ready = 1'b0;
    ov_cnt = 0;
    for (int i = 0; i < 16; i++) send_raw(1'b0, f8(8'h20 + 8'(i), 1'b0, 1'b1), 11);
    n_vec++; if (count !== 5'd16) begin n_err++; $display("FAIL pp_fill: got %0d want 16", count); end
    fork
      send_raw(1'b0, f8(8'h30, 1'b0, 1'b1), 11);
      begin
        repeat (171) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    n_vec++; if (count !== 5'd16) begin n_err++; $display("FAIL pp_count: got %0d want 16", count); end
    n_vec++; if (ov_cnt !== 0) begin n_err++; $display("FAIL pp_overrun: got %0d want 0", ov_cnt); end
    ready = 1'b1;
    idle(20);
    n_vec++; if (q1.size() !== 17) begin n_err++; $display("FAIL pp_beats: got %0d want 17", q1.size()); end
    else begin
      n_vec++; if (q1[0] !== {2'b00, 8'h20}) begin n_err++; $display("FAIL pp_first: got %h want %h", q1[0], {2'b00, 8'h20}); end
      n_vec++; if (q1[16] !== {2'b00, 8'h30}) begin n_err++; $display("FAIL pp_last: got %h want %h", q1[16], {2'b00, 8'h30}); end
    end
  endtask

  task automatic test_7n2;
    q2.delete();
    send_raw(1'b1, {6'b111111, 2'b11, 7'h5A, 1'b0}, 10);
    idle(20);
    n_vec++; if (q2.size() !== 1) begin n_err++; $display("FAIL n2_beats: got %0d want 1", q2.size()); end
    else begin
      n_vec++; if (q2[0] !== {2'b00, 7'h5A}) begin n_err++; $display("FAIL n2_word: got %h want %h", q2[0], {2'b00, 7'h5A}); end
    end
  endtask

  task automatic test_reset_midframe;
    q1.delete();
    ready = 1'b0;
    send_raw(1'b0, f8(8'hA5, 1'b0, 1'b1), 11);
    idle(4);
    n_vec++; if (count !== 5'd1) begin n_err++; $display("FAIL mf_pre_count: got %0d want 1", count); end
    rx = 1'b0;
    idle(16);
    rx = 1'b1;
    idle(16 * 3 + 8);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mf_busy: got %b want 1", busy); end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    n_vec++; if ({valid, count, busy} !== 7'd0) begin n_err++; $display("FAIL mf_reset: got %h want 0", {valid, count, busy}); end
    idle(200);
    ready = 1'b1;
    idle(2);
    n_vec++; if (q1.size() !== 0) begin n_err++; $display("FAIL mf_abort: got %0d want 0", q1.size()); end
    send_raw(1'b0, f8(8'h55, 1'b0, 1'b1), 11);
    idle(20);
    n_vec++; if (q1.size() !== 1) begin n_err++; $display("FAIL mf_beats: got %0d want 1", q1.size()); end
    else begin
      n_vec++; if (q1[0] !== {2'b00, 8'h55}) begin n_err++; $display("FAIL mf_word: got %h want %h", q1[0], {2'b00, 8'h55}); end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_basic;
    test_errors;
    test_glitch_break;
    test_overrun;
    test_full_pushpop;
    test_7n2;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
